// File: rtl/z16_instr_encoder.sv
// Z16 instruction encoder/loader: packs field beats into 16-bit words and writes them to
// instruction memory in bursts. Optional immediate range checking: Z16_ENC_RANGE_CHECK_EN.
module z16_instr_encoder #(
   parameter int ADDR_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W-1:0] i_count,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [3:0]        i_opcode,
   input  logic [3:0]        i_rd,
   input  logic [3:0]        i_rs1,
   input  logic [3:0]        i_rs2,
   input  logic [15:0]       i_imm,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [15:0]       o_mem_wdata,
   input  logic              i_mem_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_err_addr,
   output logic [1:0]        o_state
);

   // Handshakes: a beat transfers when i_valid && o_ready; a write completes when
   // o_mem_wen && i_mem_ready. Write request fields stay stable until completion.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [15:0]       out_data_q, out_data_d;

   logic [15:0] enc_word;
   logic        beat_bad;
   logic        accept;
   logic        drain;

   always_comb begin
      enc_word = {i_rs2, i_rs1, i_rd, i_opcode};
      beat_bad = 1'b0;
      case (i_opcode)
         4'h9: begin
            enc_word = {i_imm[7:0], i_rd, i_opcode};
            beat_bad = (i_rs1 != i_rd);
`ifdef Z16_ENC_RANGE_CHECK_EN
            if (i_imm[15:7] != {9{i_imm[7]}}) beat_bad = 1'b1;
`endif
         end
         4'hA: begin
            enc_word = {i_imm[3:0], i_rs1, i_rd, i_opcode};
`ifdef Z16_ENC_RANGE_CHECK_EN
            if (i_imm[15:3] != {13{i_imm[3]}}) beat_bad = 1'b1;
`endif
         end
         4'hB: begin
            enc_word = {i_rs2, i_rs1, i_imm[3:0], i_opcode};
`ifdef Z16_ENC_RANGE_CHECK_EN
            if (i_imm[15:3] != {13{i_imm[3]}}) beat_bad = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   assign drain   = out_valid_q && i_mem_ready;
   assign o_ready = (state_q == S_RUN) && (rem_q != '0) && (!out_valid_q || i_mem_ready);
   assign accept  = o_ready && i_valid;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      err_addr_d  = err_addr_q;
      // The output register drains in every state so a word accepted before an error completes.
      if (drain) out_valid_d = 1'b0;
      case (state_q)
         S_RUN: begin
            if (accept) begin
               if (beat_bad) begin
                  err_addr_d = addr_q;
                  rem_d      = '0;
                  state_d    = S_ERR;
               end else begin
                  out_valid_d = 1'b1;
                  out_addr_d  = addr_q;
                  out_data_d  = enc_word;
                  addr_d      = addr_q + 1'b1;
                  rem_d       = rem_q - 1'b1;
               end
            end else if ((rem_q == '0) && drain) begin
               state_d = S_DONE;
            end
         end
         default: begin
            if (i_start) begin
               addr_d     = i_base_addr;
               rem_d      = i_count;
               err_addr_d = '0;
               state_d    = (i_count == '0) ? S_DONE : S_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign o_mem_wen   = out_valid_q;
   assign o_mem_addr  = out_addr_q;
   assign o_mem_wdata = out_data_q;
   assign o_busy      = (state_q == S_RUN);
   assign o_done      = (state_q == S_DONE);
   assign o_err       = (state_q == S_ERR);
   assign o_err_addr  = err_addr_q;
   assign o_state     = state_q;

endmodule

// File: tb/tb_z16_instr_encoder.sv
// Self-checking bench for z16_instr_encoder: expected writes are queued when beats are
// accepted and compared when the memory write handshake happens.
module tb_z16_instr_encoder;
   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_start = 1'b0;
   logic [ADDR_W-1:0] i_base_addr = '0;
   logic [ADDR_W-1:0] i_count = '0;
   logic              i_valid = 1'b0;
   logic              o_ready;
   logic [3:0]        i_opcode = '0, i_rd = '0, i_rs1 = '0, i_rs2 = '0;
   logic [15:0]       i_imm = '0;
   logic              o_mem_wen;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [15:0]       o_mem_wdata;
   logic              i_mem_ready = 1'b1;
   logic              o_busy, o_done, o_err;
   logic [ADDR_W-1:0] o_err_addr;
   logic [1:0]        o_state;

   z16_instr_encoder #(.ADDR_W(ADDR_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
      .i_count(i_count), .i_valid(i_valid), .o_ready(o_ready), .i_opcode(i_opcode),
      .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .o_mem_wen(o_mem_wen),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_addr(o_err_addr),
      .o_state(o_state)
   );

   always #5 clk = ~clk;

   logic [31:0]       exp_q[$];
   int                n_checks = 0;
   int                n_errors = 0;
   int                n_writes = 0;
   logic [ADDR_W-1:0] exp_addr = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor: values at the negedge are those seen by the next rising edge.
   always @(negedge clk) begin
      if (!rst && o_mem_wen && i_mem_ready) begin
         n_writes++;
         if (exp_q.size() == 0) check("spurious_write", 32'(exp_q.size()), 32'd1);
         else check("mem_write", {o_mem_addr, o_mem_wdata}, exp_q.pop_front());
      end
   end

   task automatic start_burst(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt);
      i_start     = 1'b1;
      i_base_addr = base;
      i_count     = cnt;
      exp_addr    = base;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic send_beat(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                            input logic [3:0] rs2, input logic [15:0] imm,
                            input logic [15:0] exp_word, input logic is_bad, output int waits);
      i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
      i_valid  = 1'b1;
      waits    = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         waits++;
         if (o_ready) break;
      end
      if (!o_ready) check("beat_timeout", 32'(o_ready), 32'd1);
      else if (!is_bad) begin
         exp_q.push_back({exp_addr, exp_word});
         exp_addr = exp_addr + 1'b1;
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_done(output int waits);
      waits = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         waits++;
         if (o_done) break;
      end
      check("done", 32'(o_done), 32'd1);
      check("busy_after_done", 32'(o_busy), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic std_burst_beats(input int n, output int w);
      case (n)
         0: send_beat(4'h0, 4'd3, 4'd1, 4'd2, 16'h0000, 16'h2130, 1'b0, w);
         1: send_beat(4'h9, 4'd5, 4'd5, 4'd0, 16'hFFFD, 16'hFD59, 1'b0, w);
         2: send_beat(4'hA, 4'd4, 4'd2, 4'd0, 16'hFFFF, 16'hF24A, 1'b0, w);
         default: send_beat(4'hB, 4'd0, 4'd6, 4'd7, 16'h0003, 16'h763B, 1'b0, w);
      endcase
   endtask

   initial begin
      int w;
      int writes_before;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(o_ready), 32'd0);
      check("rst_wen", 32'(o_mem_wen), 32'd0);
      check("rst_addr", 32'(o_mem_addr), 32'd0);
      check("rst_wdata", 32'(o_mem_wdata), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_err_addr", 32'(o_err_addr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic burst, full throughput
      start_burst(16'h0010, 16'd4);
      check("busy_run", 32'(o_busy), 32'd1);
      for (int n = 0; n < 4; n++) begin
         std_burst_beats(n, w);
         check("throughput_wait", 32'(w), 32'd1);
      end
      wait_done(w);
      check("done_latency", 32'(w), 32'd2);
      check("no_err", 32'(o_err), 32'd0);

      // Same burst with memory back-pressure on the second write
      start_burst(16'h0010, 16'd4);
      check("done_cleared", 32'(o_done), 32'd0);
      std_burst_beats(0, w);
      std_burst_beats(1, w);
      i_mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_wen", 32'(o_mem_wen), 32'd1);
         check("stall_addr", 32'(o_mem_addr), 32'h0011);
         check("stall_wdata", 32'(o_mem_wdata), 32'hFD59);
         check("stall_ready", 32'(o_ready), 32'd0);
      end
      @(posedge clk); #1;
      i_mem_ready = 1'b1;
      std_burst_beats(2, w);
      std_burst_beats(3, w);
      wait_done(w);

      // Address wrap
      start_burst(16'hFFFF, 16'd2);
      send_beat(4'h0, 4'd1, 4'd2, 4'd3, 16'h0000, 16'h3210, 1'b0, w);
      send_beat(4'hC, 4'd4, 4'd5, 4'd6, 16'h0000, 16'h654C, 1'b0, w);
      wait_done(w);

`ifdef Z16_ENC_RANGE_CHECK_EN
      start_burst(16'h0020, 16'd4);
      send_beat(4'h0, 4'd3, 4'd1, 4'd2, 16'h0000, 16'h2130, 1'b0, w);
      send_beat(4'h9, 4'd1, 4'd1, 4'd0, 16'd200, 16'h0000, 1'b1, w);
      repeat (3) @(negedge clk);
      check("range_err", 32'(o_err), 32'd1);
      check("range_err_addr", 32'(o_err_addr), 32'h0021);
      check("range_done", 32'(o_done), 32'd0);
      check("range_ready", 32'(o_ready), 32'd0);
      check("range_queue", 32'(exp_q.size()), 32'd0);
`else
      start_burst(16'h0030, 16'd3);
      send_beat(4'h9, 4'd1, 4'd1, 4'd0, 16'd200, 16'hC819, 1'b0, w);
      send_beat(4'h9, 4'd1, 4'd2, 4'd0, 16'h0000, 16'h0000, 1'b1, w);
      repeat (3) @(negedge clk);
      check("rs_err", 32'(o_err), 32'd1);
      check("rs_err_addr", 32'(o_err_addr), 32'h0031);
      check("rs_done", 32'(o_done), 32'd0);
      check("rs_queue", 32'(exp_q.size()), 32'd0);
`endif
      @(posedge clk); #1;

      // Start from ERR clears the error; rs1 != rd on first beat
      start_burst(16'h0050, 16'd2);
      check("err_cleared", 32'(o_err), 32'd0);
      check("err_addr_cleared", 32'(o_err_addr), 32'd0);
      send_beat(4'h9, 4'd2, 4'd3, 4'd0, 16'h0001, 16'h0000, 1'b1, w);
      @(negedge clk);
      check("rs_err2", 32'(o_err), 32'd1);
      check("rs_err_addr2", 32'(o_err_addr), 32'h0050);
      @(posedge clk); #1;

      // Asynchronous reset while a write is pending
      start_burst(16'h0040, 16'd4);
      i_mem_ready = 1'b0;
      std_burst_beats(0, w);
      @(negedge clk);
      check("pre_rst_wen", 32'(o_mem_wen), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_wen", 32'(o_mem_wen), 32'd0);
      check("async_busy", 32'(o_busy), 32'd0);
      check("async_ready", 32'(o_ready), 32'd0);
      check("async_wdata", 32'(o_mem_wdata), 32'd0);
      check("async_state", 32'(o_state), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      i_mem_ready = 1'b1;
      writes_before = n_writes;
      start_burst(16'h0060, 16'd0);
      check("zero_count_done", 32'(o_done), 32'd1);
      check("zero_count_busy", 32'(o_busy), 32'd0);
      repeat (3) @(negedge clk);
      check("zero_count_writes", 32'(n_writes), 32'(writes_before));
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/z16_instr_encoder.md
# z16_instr_encoder

Sequential instruction encoder and loader for the Z16 core: accepts decoded instruction fields (opcode, register addresses, immediate) over a valid/ready stream, packs them into 16-bit Z16 instruction words and writes them into instruction memory at consecutive addresses. It sits between the host/debug loader path and the instruction memory write port, and performs the exact inverse of the Z16 decode packing. A start/count FSM bounds each load burst, and bad fields raise a sticky error.

## Interface
- ADDR_W, 16, width of instruction-memory word address and burst count
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse; begins a burst (honoured in IDLE/DONE/ERR only)
- i_base_addr  in  ADDR_W  first write address, latched on i_start
- i_count  in  ADDR_W  number of instructions in burst, latched on i_start
- i_valid  in  1  field beat valid
- o_ready  out  1  encoder accepts beat this cycle
- i_opcode / i_rd / i_rs1 / i_rs2  in  4 each  instruction fields
- i_imm  in  16  signed immediate
- o_mem_wen  out  1  memory write request
- o_mem_addr  out  ADDR_W  write address
- o_mem_wdata  out  16  encoded instruction
- i_mem_ready  in  1  memory accepts write this cycle
- o_busy  out  1  FSM in RUN
- o_done  out  1  burst complete (level, until next i_start)
- o_err  out  1  sticky field error
- o_err_addr  out  ADDR_W  address of rejected beat

## Operation
- Encoding (bit fields [15:12],[11:8],[7:4],[3:0]):
  - opcode 0x0–0x8 (ALU) and 0xC–0xF: {rs2, rs1, rd, op}
  - 0x9 ADDI: {imm[7:0], rd, op}; i_rs1 must equal i_rd
  - 0xA LOAD: {imm[3:0], rs1, rd, op}
  - 0xB STORE: {rs2, rs1, imm[3:0], op}
- Field check (see Configuration): ADDI imm in −128..127; LOAD/STORE imm in −8..7; ADDI i_rs1 == i_rd always checked.
- FSM states: IDLE → (i_start, count≠0) RUN; IDLE/DONE/ERR → (i_start, count=0) DONE; RUN → DONE when last write handshakes; RUN → ERR on accepting a bad beat; DONE/ERR → RUN on i_start with count≠0.
- Internal: write-address counter, remaining-accept counter, one-entry output register (valid + addr + data).
- o_ready = RUN && remaining≠0 && (!out_valid || i_mem_ready).
- Accepted good beat loads output register, increments address, decrements remaining.
- Bad beat: not written; o_err_addr ← address it would have used; o_err set; FSM → ERR. A word already in the output register still completes.
- Address wraps modulo 2^ADDR_W; no error on wrap.
- i_start in RUN ignored. i_start clears o_done, o_err, o_err_addr.

## Timing
- Reset values: o_ready 0, o_mem_wen 0, o_mem_addr 0, o_mem_wdata 0, o_busy 0, o_done 0, o_err 0, o_err_addr 0; FSM IDLE.
- Reset mid-burst: all outputs drop to reset values immediately (async); pending write discarded.
- Latency: beat accepted in cycle N → o_mem_wen=1 with data in cycle N+1.
- o_mem_wen/addr/wdata held stable while i_mem_ready=0; write completes on o_mem_wen && i_mem_ready.
- Throughput: one instruction per cycle with i_mem_ready held high (accept and drain same cycle).
- o_done rises the cycle after the last write handshake; o_busy falls same cycle.
- o_ready is 0 in the first RUN cycle only if output register full and not draining.

## Configuration
- Z16_ENC_RANGE_CHECK_EN defined: out-of-range immediates are rejected as field errors per Operation.
- Undefined: immediates truncated silently to field width (imm[7:0] or imm[3:0]); only the ADDI rs1==rd check can raise o_err.

## Test plan
- Start base=0x0010 count=4; beats ADD(op0,rd3,rs1 1,rs2 2), ADDI(rd5,rs1 5,imm −3), LOAD(rd4,rs1 2,imm −1), STORE(rs1 6,rs2 7,imm 3) → writes 0x2130@0x10, 0xFD59@0x11, 0xF24A@0x12, 0x763B@0x13; o_done=1.
- Same burst with i_mem_ready low for 3 cycles on 2nd write → o_mem_wdata/addr held, o_ready=0, all four words written in order.
- base=0xFFFF count=2 → writes at 0xFFFF then 0x0000.
- Macro defined: ADDI rd1 imm=200 as 2nd beat, base 0x20 → first word written, o_err=1, o_err_addr=0x21, no write to 0x21, o_done=0.
- Macro undefined: ADDI rd1 rs1 1 imm=200 → 0xC819 written, no error; ADDI rd1 rs1 2 → o_err=1.
- Assert i_rst while output register full mid-burst → o_mem_wen=0 same cycle, FSM IDLE; count=0 start → o_done next cycle, no writes.
